// File: rtl/blocking_in_accumulator.sv
// blocking_in_accumulator
//   Consumer end of the blocking sync/notify handshake. Reads COUNT signed
//   values from the input port and sums them (wrapping modulo 2^WIDTH), then
//   offers the block sum plus a signed-overflow flag on the output port and
//   returns to reading once the reader has taken it.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   b_in          input data, sampled only on an input transfer
//   b_in_sync     writer offers b_in this cycle
//   b_in_notify   block is ready to read (read_st)
//   b_out         block sum, valid while b_out_notify=1
//   b_out_sync    reader accepts b_out this cycle
//   b_out_notify  block offers b_out (write_st)
//   ovf_out       signed overflow occurred during the block on b_out
//   blk_cnt_out   completed output transfers since reset, wraps 255->0
//
// A transfer happens at a rising edge when notify and sync are both 1.
// Every output comes straight from a flop; the notify pair is decoded from
// the single state flop, so they can never be high together.
module blocking_in_accumulator #(
  parameter int COUNT = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] b_in,
  input  logic             b_in_sync,
  output logic             b_in_notify,
  output logic [WIDTH-1:0] b_out,
  input  logic             b_out_sync,
  output logic             b_out_notify,
  output logic             ovf_out,
  output logic [7:0]       blk_cnt_out
);

  typedef enum logic {READ_ST = 1'b0, WRITE_ST = 1'b1} state_t;

  localparam logic [7:0] LAST = 8'(COUNT - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [7:0]       cnt, cnt_n;
  logic             ovf, ovf_n;
  logic [WIDTH-1:0] out_n;
  logic             ovf_out_n;
  logic [7:0]       blk_n;

  logic [WIDTH-1:0] sum;
  logic             ovf_step;

  // Signed overflow: both operands share a sign and the wrapped sum does not.
  assign sum      = acc + b_in;
  assign ovf_step = (acc[WIDTH-1] == b_in[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    cnt_n     = cnt;
    ovf_n     = ovf;
    out_n     = b_out;
    ovf_out_n = ovf_out;
    blk_n     = blk_cnt_out;
    case (state)
      READ_ST: begin
        if (b_in_sync) begin
          if (cnt == LAST) begin
            // Last word of the block: publish and clear the running state.
            out_n     = sum;
            ovf_out_n = ovf | ovf_step;
            acc_n     = '0;
            cnt_n     = '0;
            ovf_n     = 1'b0;
            state_n   = WRITE_ST;
          end else begin
            acc_n = sum;
            cnt_n = cnt + 8'd1;
            ovf_n = ovf | ovf_step;
          end
        end
      end
      WRITE_ST: begin
        // b_out/ovf_out hold; input side is ignored until the reader takes it.
        if (b_out_sync) begin
          blk_n   = blk_cnt_out + 8'd1;
          state_n = READ_ST;
        end
      end
      default: state_n = READ_ST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= READ_ST;
      acc         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      b_out       <= '0;
      ovf_out     <= 1'b0;
      blk_cnt_out <= '0;
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      cnt         <= cnt_n;
      ovf         <= ovf_n;
      b_out       <= out_n;
      ovf_out     <= ovf_out_n;
      blk_cnt_out <= blk_n;
    end
  end

  assign b_in_notify  = (state == READ_ST);
  assign b_out_notify = (state == WRITE_ST);

endmodule

// File: doc/blocking_in_accumulator.md
Name: blocking_in_accumulator

Overview:
- Consumer end of the blocking sync/notify port handshake used by the generated property-skeleton modules.
- Reads COUNT values from a blocking input port and sums them.
- Offers the block sum on a blocking output port, with an overflow flag, then returns to reading.
- Sits downstream of any module with a blocking integer output port; its own output feeds a standard blocking reader.

Parameters:
- COUNT, 4, number of values summed per block; legal range 1..255.
- WIDTH, 32, data width; signed two's complement, matching the codebase integer type.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- b_in  input  WIDTH  data from writer; sampled only on a transfer
- b_in_sync  input  1  writer offers data this cycle
- b_in_notify  output  1  this block is ready to read
- b_out  output  WIDTH  block sum; valid while b_out_notify=1
- b_out_sync  input  1  reader accepts data this cycle
- b_out_notify  output  1  this block offers b_out
- ovf_out  output  1  signed overflow occurred during the block now on b_out
- blk_cnt_out  output  8  completed output transfers since reset, wraps 255->0

Behaviour:
- Transfer rule: a port transfers at a rising clk edge when its notify and its sync are both 1. Nothing happens on a port otherwise. sync may toggle arbitrarily and never needs to stay high.
- Reset values (asynchronous, applied while rst=1):
  - section=read_st
  - b_in_notify=1, b_out_notify=0
  - b_out=0, ovf_out=0, blk_cnt_out=0
  - internal acc=0, cnt=0, ovf=0
- State read_st (b_in_notify=1, b_out_notify=0):
  - On an input transfer: sum = acc + b_in, signed WIDTH-bit, wraps modulo 2^WIDTH.
  - ovf_next = ovf | (acc and b_in have the same sign and sum has a different sign).
  - If cnt < COUNT-1: acc<=sum, cnt<=cnt+1, ovf<=ovf_next.
  - If cnt == COUNT-1: b_out<=sum, ovf_out<=ovf_next, b_out_notify<=1, b_in_notify<=0, acc<=0, cnt<=0, ovf<=0, section<=write_st.
- State write_st (b_in_notify=0, b_out_notify=1):
  - b_out and ovf_out are held stable.
  - b_in and b_in_sync are ignored.
  - On an output transfer: b_out_notify<=0, b_in_notify<=1, blk_cnt_out<=blk_cnt_out+1, section<=read_st. b_out and ovf_out keep their last value.
- Latency:
  - The final input transfer at edge N gives b_out_notify=1 after edge N.
  - An output transfer at edge M gives b_in_notify=1 after edge M.
  - Minimum period is COUNT+1 cycles per block when both sync inputs are held at 1.
- Both notify outputs are never 1 in the same cycle.
- COUNT=1: every input transfer goes directly to write_st; b_out equals b_in.
- Reset mid-block discards the partial acc, cnt and ovf. A pending output is dropped with b_out_notify=0 immediately, and b_in_notify=1 while rst is high.
- All outputs are registered; no combinational path from any input to any output.

Test Plan:
- COUNT=4, b_in_sync=1 with data 1,2,3,4 on consecutive cycles, b_out_sync=1 -> b_out=10, ovf_out=0, b_out_notify high for 1 cycle, blk_cnt_out=1, b_in_notify back to 1 the next cycle.
- Same data with b_out_sync=0 for 5 cycles -> b_out_notify held at 1 and b_out=10 stable; b_in_notify=0 throughout; then b_out_sync=1 -> transfer completes and blk_cnt_out increments.
- Gapped writer: b_in_sync pulsed every 3rd cycle with -5,7,-2,0 -> b_out=0 only after the 4th transfer; cnt does not advance on non-transfer cycles.
- Overflow: 0x7FFFFFFF,1,0,0 -> b_out=0x80000000, ovf_out=1. The next block 1,1,1,1 -> b_out=4, ovf_out=0 (ovf cleared per block).
- Reset mid-block: after 2 transfers (5,5), assert rst -> outputs at reset values. Then 1,1,1,1 -> b_out=4.
- Wrap: 256 completed blocks -> blk_cnt_out returns to 0.
